// File: rtl/fnd_scan_driver.sv
// Multi-digit 7-segment scan driver: tear-free latched value, guarded digit slots,
// hex/dash decode, leading-zero blanking and selectable output polarity.
module fnd_scan_driver #(
    parameter int NUM_DIGITS      = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int GUARD           = 2,
    parameter bit SEG_ACTIVE_HIGH = 1'b1,
    parameter bit DIG_ACTIVE_LOW  = 1'b1
) (
    input  logic                    iClk,
    input  logic                    iRsn,
    input  logic                    iEn,
    input  logic                    iLoad,
    input  logic [4*NUM_DIGITS-1:0] iData,
    input  logic [NUM_DIGITS-1:0]   iDp,
    input  logic                    iHexMode,
    input  logic                    iBlankLz,
    output logic [6:0]              oSeg,
    output logic                    oDp,
    output logic [NUM_DIGITS-1:0]   oDigit,
    output logic                    oFrameDone
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         I_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF = {7{~SEG_ACTIVE_HIGH}};
    localparam logic                  DP_OFF  = ~SEG_ACTIVE_HIGH;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;

    logic                  w_slot_end, w_frame_end, w_in_guard;
    logic [NUM_DIGITS-1:0] w_zero, w_blank, w_sel;
    logic [3:0]            w_code;
    logic                  w_dp_sel, w_blank_sel, w_dp_on;
    logic [6:0]            w_pat;

    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex);
        logic [6:0] pat;
        case (code)
            4'h0: pat = 7'b1111110;
            4'h1: pat = 7'b0110000;
            4'h2: pat = 7'b1101101;
            4'h3: pat = 7'b1111001;
            4'h4: pat = 7'b0110011;
            4'h5: pat = 7'b1011011;
            4'h6: pat = 7'b1011111;
            4'h7: pat = 7'b1110010;
            4'h8: pat = 7'b1111111;
            4'h9: pat = 7'b1111011;
            4'hA: pat = 7'b1110111;
            4'hB: pat = 7'b0011111;
            4'hC: pat = 7'b1001110;
            4'hD: pat = 7'b0111101;
            4'hE: pat = 7'b1001111;
            default: pat = 7'b1000111;
        endcase
        if (code > 4'd9 && !hex) pat = 7'b0000001;
        return pat;
    endfunction

    assign w_slot_end  = (r_presc == P_LAST);
    assign w_frame_end = w_slot_end && (r_idx == I_LAST);
    assign w_in_guard  = ({1'b0, r_presc} < (PW+1)'(GUARD));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (!iEn) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_idx   <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // NOTE: value registers are reset so the first frame after reset shows zeros, not X.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
        end else begin
            if (iLoad) begin
                r_pend_data <= iData;
                r_pend_dp   <= iDp;
            end
            // Copy on the edge entering the digit-0 slot so a frame never mixes two loads.
            if (!iEn || w_frame_end) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
            end
        end
    end

    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        w_code   = '0;
        w_dp_sel = 1'b0;
        w_zero   = '0;
        w_sel    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero[i] = (r_act_data[4*i +: 4] == 4'd0) && !r_act_dp[i];
            w_sel[i]  = (r_idx == IW'(i));
            if (w_sel[i]) begin
                w_code   = r_act_data[4*i +: 4];
                w_dp_sel = r_act_dp[i];
            end
        end
    end

    always_comb begin
        logic w_lead;
        w_blank = '0;
        w_lead  = iBlankLz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lead     = w_lead && w_zero[i];
            w_blank[i] = w_lead;
        end
    end

    assign w_blank_sel = |(w_blank & w_sel);
    assign w_pat       = w_blank_sel ? 7'b0000000 : seg_decode(w_code, iHexMode);
    assign w_dp_on     = w_dp_sel && !w_blank_sel;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            oSeg       <= SEG_OFF;
            oDp        <= DP_OFF;
            oDigit     <= DIG_OFF;
            oFrameDone <= 1'b0;
        end else if (!iEn) begin
            oSeg       <= SEG_OFF;
            oDp        <= DP_OFF;
            oDigit     <= DIG_OFF;
            oFrameDone <= 1'b0;
        end else begin
            oSeg       <= SEG_ACTIVE_HIGH ? w_pat : ~w_pat;
            oDp        <= SEG_ACTIVE_HIGH ? w_dp_on : ~w_dp_on;
            oDigit     <= w_in_guard ? DIG_OFF : (DIG_ACTIVE_LOW ? ~w_sel : w_sel);
            oFrameDone <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: default-polarity and inverted-polarity instances
// driven from shared inputs, with expected patterns written out by hand.
module tb_fnd_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int GRD = 2;

    localparam logic [6:0] S0   = 7'h7E;
    localparam logic [6:0] S1   = 7'h30;
    localparam logic [6:0] S2   = 7'h6D;
    localparam logic [6:0] S3   = 7'h79;
    localparam logic [6:0] S4   = 7'h33;
    localparam logic [6:0] S5   = 7'h5B;
    localparam logic [6:0] SA   = 7'h77;
    localparam logic [6:0] SF   = 7'h47;
    localparam logic [6:0] DASH = 7'h01;
    localparam logic [6:0] OFF  = 7'h00;

    logic        clk = 1'b0;
    logic        rst_n, en, load, hex, blz;
    logic [15:0] data;
    logic [3:0]  dp;

    logic [6:0] seg, seg_i;
    logic       odp, odp_i, fd, fd_i;
    logic [3:0] dig, dig_i;

    int n_total = 0;
    int n_pass  = 0;
    int k;
    int lit_cnt[N];
    int fd_cnt;

    always #5 clk = ~clk;

    fnd_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .GUARD(GRD)) dut (
        .iClk(clk), .iRsn(rst_n), .iEn(en), .iLoad(load), .iData(data), .iDp(dp),
        .iHexMode(hex), .iBlankLz(blz),
        .oSeg(seg), .oDp(odp), .oDigit(dig), .oFrameDone(fd)
    );

    fnd_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .GUARD(GRD),
                      .SEG_ACTIVE_HIGH(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_inv (
        .iClk(clk), .iRsn(rst_n), .iEn(en), .iLoad(load), .iData(data), .iDp(dp),
        .iHexMode(hex), .iBlankLz(blz),
        .oSeg(seg_i), .oDp(odp_i), .oDigit(dig_i), .oFrameDone(fd_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " seg"},    {25'b0, seg},   32'h00);
        check({tag, " dp"},     {31'b0, odp},   32'h0);
        check({tag, " dig"},    {28'b0, dig},   32'hF);
        check({tag, " fd"},     {31'b0, fd},    32'h0);
        check({tag, " seg_i"},  {25'b0, seg_i}, 32'h7F);
        check({tag, " dp_i"},   {31'b0, odp_i}, 32'h1);
        check({tag, " dig_i"},  {28'b0, dig_i}, 32'h0);
        check({tag, " fd_i"},   {31'b0, fd_i},  32'h0);
    endtask

    // es holds the expected pattern of digit i at [i*7 +: 7]; k counts clocks since iEn rose.
    task automatic run_steps(input int n, input logic [27:0] es, input logic [3:0] edp);
        for (int s = 0; s < n; s++) begin
            int p, d;
            logic [6:0] e_seg, e_seg_n;
            logic [3:0] e_dig, e_dig_i;
            logic       e_dp, e_dp_n, e_fd;
            @(posedge clk);
            @(negedge clk);
            k++;
            p       = (k - 1) % DIV;
            d       = ((k - 1) / DIV) % N;
            e_seg   = es[d*7 +: 7];
            e_seg_n = ~e_seg;
            e_dp    = edp[d];
            e_dp_n  = ~e_dp;
            e_dig_i = (p < GRD) ? 4'b0000 : (4'b0001 << d);
            e_dig   = ~e_dig_i;
            e_fd    = (p == DIV - 1) && (d == N - 1);
            check($sformatf("dig k=%0d", k),   {28'b0, dig},   {28'b0, e_dig});
            check($sformatf("seg k=%0d", k),   {25'b0, seg},   {25'b0, e_seg});
            check($sformatf("dp k=%0d", k),    {31'b0, odp},   {31'b0, e_dp});
            check($sformatf("fd k=%0d", k),    {31'b0, fd},    {31'b0, e_fd});
            check($sformatf("dig_i k=%0d", k), {28'b0, dig_i}, {28'b0, e_dig_i});
            check($sformatf("seg_i k=%0d", k), {25'b0, seg_i}, {25'b0, e_seg_n});
            check($sformatf("dp_i k=%0d", k),  {31'b0, odp_i}, {31'b0, e_dp_n});
            for (int i = 0; i < N; i++) if (!dig[i]) lit_cnt[i]++;
            if (fd) fd_cnt++;
        end
    endtask

    // Called at a negedge: two idle clocks load pending then copy it to active.
    task automatic start_scan(input logic [15:0] v, input logic [3:0] p);
        en   = 1'b0;
        load = 1'b1;
        data = v;
        dp   = p;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        en = 1'b1;
        k  = 0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; dp = '0; hex = 1'b0; blz = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain decimal frame, lit-time and frame-pulse counting.
        start_scan(16'h1234, 4'b0000);
        for (int i = 0; i < N; i++) lit_cnt[i] = 0;
        fd_cnt = 0;
        run_steps(32, {S1, S2, S3, S4}, 4'b0000);
        for (int i = 0; i < N; i++) check($sformatf("lit_cnt[%0d]", i), lit_cnt[i], 6);
        check("fd_cnt frame1", fd_cnt, 1);
        run_steps(32, {S1, S2, S3, S4}, 4'b0000);
        check("fd_cnt frame2", fd_cnt, 2);

        // Leading-zero blanking, then a DP stopping the blanking.
        blz = 1'b1;
        start_scan(16'h0025, 4'b0000);
        run_steps(32, {OFF, OFF, S2, S5}, 4'b0000);
        start_scan(16'h0025, 4'b0100);
        run_steps(32, {OFF, S0, S2, S5}, 4'b0100);

        // Hex mode versus dash.
        blz = 1'b0;
        hex = 1'b1;
        start_scan(16'h00AF, 4'b0000);
        run_steps(32, {S0, S0, SA, SF}, 4'b0000);
        hex = 1'b0;
        start_scan(16'h00AF, 4'b0000);
        run_steps(32, {S0, S0, DASH, DASH}, 4'b0000);

        // Load during digit-2 slot becomes visible only from the next frame.
        start_scan(16'h1111, 4'b0000);
        run_steps(18, {S1, S1, S1, S1}, 4'b0000);
        load = 1'b1;
        data = 16'h2222;
        run_steps(1, {S1, S1, S1, S1}, 4'b0000);
        load = 1'b0;
        run_steps(13, {S1, S1, S1, S1}, 4'b0000);
        run_steps(32, {S2, S2, S2, S2}, 4'b0000);
        run_steps(10, {S2, S2, S2, S2}, 4'b0000);

        // Enable dropped mid-frame, then restored.
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("en_off");
        @(negedge clk);
        check_idle("en_off2");
        en = 1'b1;
        k  = 0;
        run_steps(12, {S2, S2, S2, S2}, 4'b0000);

        // Asynchronous reset mid-scan, then a frame from the cleared registers.
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run_steps(32, {S0, S0, S0, S0}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Parametrised multi-digit 7-segment (FND) scan driver, successor to the combinational single-digit decoder. Latches an N-digit 4-bit-per-digit value, time-multiplexes the digits onto one shared segment bus with a programmable slot length and an anti-ghosting guard, and adds hex mode, leading-zero blanking, per-digit decimal point and polarity options. It sits between the temperature formatting logic and the board FND pins.

## Interface
- NUM_DIGITS, 4, digit count (≥1)
- SCAN_DIV, 1000, clocks per digit slot (≥2)
- GUARD, 2, clocks at start of each slot with all digits off (0 ≤ GUARD < SCAN_DIV)
- SEG_ACTIVE_HIGH, 1, 1: segment/DP lit = 1; 0: lit = 0
- DIG_ACTIVE_LOW, 1, 1: selected digit enable = 0; 0: = 1
- iClk  in  1  system clock, all logic rising-edge
- iRsn  in  1  reset, asynchronous, active-low
- iEn  in  1  scan enable
- iLoad  in  1  capture iData/iDp into pending register
- iData  in  4*NUM_DIGITS  digit codes, [3:0] = digit 0 (least significant)
- iDp  in  NUM_DIGITS  decimal point per digit
- iHexMode  in  1  1: codes 10–15 shown as A,b,C,d,E,F
- iBlankLz  in  1  leading-zero blanking enable
- oSeg  out  7  segments, bit6=a … bit0=g
- oDp  out  1  decimal point
- oDigit  out  NUM_DIGITS  one-hot digit enable
- oFrameDone  out  1  one-cycle pulse at end of each full scan

## Operation
- Active-high segment pattern (before polarity): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011; hex: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; codes 10–15 with iHexMode=0 → 0000001 (dash).
- Pending register: loaded from iData/iDp on any cycle with iLoad=1, regardless of iEn.
- Active register: copied from pending at the start of every digit-0 slot and on every cycle with iEn=0; display never shows a mix of two loads (tear-free).
- Prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and digit index advances 0→1→…→NUM_DIGITS-1→0.
- oFrameDone = 1 for the one cycle in which index wraps NUM_DIGITS-1→0.
- Leading-zero blanking (iBlankLz=1): scanning from digit NUM_DIGITS-1 downward, digits with code 0 and DP clear are blanked (segments off) until the first digit that is nonzero or has DP set; that digit and all lower ones display. Digit 0 is never blanked. DP of a blanked digit is off by construction.
- Guard: for prescaler values 0..GUARD-1 of each slot, oDigit is all-inactive; oSeg/oDp already carry the new digit's pattern.
- iEn=0: prescaler and index held at 0, oDigit/oSeg/oDp inactive, oFrameDone 0. On iEn rising, scan starts with a digit-0 slot, prescaler 0.
- iLoad in the same cycle as the active-register copy: the copy takes the old pending value; the new value appears at the next frame.

## Timing
- Reset (iRsn=0, async): prescaler 0, index 0, pending and active 0; oSeg and oDp inactive level (all 0 if SEG_ACTIVE_HIGH else all 1), oDigit all-inactive, oFrameDone 0.
- All outputs registered; they reflect prescaler/index state with 1-clock latency.
- Frame period = NUM_DIGITS × SCAN_DIV clocks; each digit lit SCAN_DIV − GUARD clocks per frame.
- iLoad → visible: at most one frame + 1 clock after the next digit-0 slot start.
- Reset deassertion mid-frame is not possible; assertion mid-frame forces reset values immediately (async).

## Test plan
- NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, defaults: load iData=16'h1234, iDp=0 → over one 32-clock frame oDigit (active-low) = 1110,1101,1011,0111 each lit 6 clocks; oSeg = 4,3,2,1 patterns; oFrameDone pulses once per 32 clocks.
- iBlankLz=1, iData=16'h0025, iDp=4'b0000 → digits 3,2 segments off, digits 1,0 show 2,5; then iDp=4'b0100 → digit 2 shows 0 with DP, digit 3 blank.
- iData=16'h00AF: iHexMode=1 → A,F patterns 1110111/1000111; iHexMode=0 → both 0000001.
- Load 16'h1111 then 16'h2222 mid-frame (digit 2 slot) → remaining slots of that frame show 1; next frame shows 2 in all digits.
- iEn dropped mid-frame → next clock all outputs inactive; iEn restored → digit-0 slot begins, guard 2 clocks then lit.
- SEG_ACTIVE_HIGH=0, DIG_ACTIVE_LOW=0, iRsn pulsed low mid-scan → oSeg=1111111, oDp=1, oDigit=0000 immediately, oFrameDone=0.
